// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
//   Shared definitions for the sequential ALU: opcode encodings, FSM state
//   encodings and the default datapath width.
//
//   Optional feature macro: ALU_DIV_EN adds the ST_DIV state used by the
//   unsigned divider. Opcodes 11/12 are always defined here so that software
//   and test code can name them; without the macro they decode as undefined.
// -----------------------------------------------------------------------------
package alu_seq_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Opcodes 0-5 keep the legacy 3-bit datapath ALU encodings.
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
`ifdef ALU_DIV_EN
    ,
    ST_DIV  = 2'd3
`endif
  } state_e;

endpackage : alu_seq_pkg

// File: rtl/alu_seq_comb.sv
// -----------------------------------------------------------------------------
// alu_seq_comb
//   Purely combinational single-cycle ALU operations plus flag generation.
//   Multi-cycle opcodes (MUL, DIVU, REMU) and undefined opcodes produce a zero
//   result here; the sequential wrapper substitutes the iterative result.
//
//   Ports
//     a_i, b_i   [WIDTH-1:0]  operands
//     func_i     [3:0]        opcode
//     result_o   [WIDTH-1:0]  operation result
//     zero_o                  result == 0
//     neg_o                   result[WIDTH-1]
//     ovf_o                   signed overflow (ADD/SUB only)
//     carry_o                 ADD carry-out / SUB borrow (a < b unsigned)
// -----------------------------------------------------------------------------
module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       func_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             neg_o,
  output logic             ovf_o,
  output logic             carry_o
);

  localparam int SHAMT_W = $clog2(WIDTH);

  logic [WIDTH:0]     sum_ext;
  logic [WIDTH-1:0]   diff;
  logic [SHAMT_W-1:0] shamt;

  assign sum_ext = {1'b0, a_i} + {1'b0, b_i};
  assign diff    = a_i - b_i;
  assign shamt   = b_i[SHAMT_W-1:0];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through
    // the case statement leaves a signal unassigned and no latch is inferred.
    result_o = '0;
    ovf_o    = 1'b0;
    carry_o  = 1'b0;
    case (func_i)
      OP_ADD: begin
        result_o = sum_ext[WIDTH-1:0];
        carry_o  = sum_ext[WIDTH];
        ovf_o    = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                   (sum_ext[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        result_o = diff;
        carry_o  = (a_i < b_i);
        ovf_o    = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                   (diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_NOR:  result_o = ~(a_i | b_i);
      OP_SLT:  result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: result_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      OP_SLL:  result_o = a_i << shamt;
      OP_SRL:  result_o = a_i >> shamt;
      OP_SRA:  result_o = WIDTH'($signed(a_i) >>> shamt);
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);
  assign neg_o  = result_o[WIDTH-1];

endmodule : alu_seq_comb

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
//   Handshaked, parametrised ALU. Single-cycle operations are computed by
//   alu_seq_comb and registered on the accepting edge; MUL (and, with the
//   ALU_DIV_EN macro defined, DIVU/REMU) run an iterative one-bit-per-cycle
//   engine for WIDTH cycles. Results and flags are held in HOLD until the
//   consumer takes them with out_ready.
//
//   Optional feature macro: ALU_DIV_EN (unsigned restoring divider, state DIV).
//
//   Ports
//     clk, rst_n                  clock, asynchronous active-low reset
//     in_valid / in_ready         operation offer / block idle and accepting
//     a, b [WIDTH-1:0], func[3:0] operands and opcode
//     out_valid / out_ready       result presented / consumer takes it
//     out [WIDTH-1:0]             registered result
//     zero_flag, neg_flag         out == 0, out[WIDTH-1]
//     ovf_flag, carry_flag        ADD/SUB overflow and carry/borrow
//     busy                        multi-cycle operation in progress
// -----------------------------------------------------------------------------
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             ovf_flag,
  output logic             carry_flag,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  // op_a: multiplicand (shifted left) / divisor
  // op_b: multiplier (shifted right) / dividend shifting into quotient
  // acc : product accumulator / partial remainder
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
  logic             carry_q, carry_d;

  logic [WIDTH-1:0] comb_result;
  logic             comb_zero, comb_neg, comb_ovf, comb_carry;
  logic [WIDTH-1:0] mul_acc_next;
  logic             last_step;

  alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
    .a_i      (a),
    .b_i      (b),
    .func_i   (func),
    .result_o (comb_result),
    .zero_o   (comb_zero),
    .neg_o    (comb_neg),
    .ovf_o    (comb_ovf),
    .carry_o  (comb_carry)
  );

  // Radix-2 shift-add: only the low WIDTH product bits are kept, so shifting
  // the multiplicand out of range simply drops terms above 2^WIDTH.
  assign mul_acc_next = acc_q + (op_b_q[0] ? op_a_q : '0);
  assign last_step    = (cnt_q == CNT_W'(1));

`ifdef ALU_DIV_EN
  logic [3:0]       func_q, func_d;
  logic [WIDTH:0]   div_trial;
  logic             div_fits;
  logic [WIDTH-1:0] div_rem_next;
  logic [WIDTH-1:0] div_quo_next;
  logic [WIDTH-1:0] div_result;

  // Restoring division: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits. The difference is below the divisor,
  // so computing it on the low WIDTH bits is exact. A zero divisor always
  // "fits", which yields an all-ones quotient and remainder == a.
  assign div_trial    = {acc_q, op_b_q[WIDTH-1]};
  assign div_fits     = (div_trial >= {1'b0, op_a_q});
  assign div_rem_next = div_fits ? (div_trial[WIDTH-1:0] - op_a_q) : div_trial[WIDTH-1:0];
  assign div_quo_next = {op_b_q[WIDTH-2:0], div_fits};
  assign div_result   = (func_q == OP_DIVU) ? div_quo_next : div_rem_next;
`endif

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    carry_d = carry_q;
`ifdef ALU_DIV_EN
    func_d  = func_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (func == OP_MUL) begin
            op_a_d  = a;
            op_b_d  = b;
            acc_d   = '0;
            cnt_d   = CNT_W'(WIDTH);
            state_d = ST_MUL;
          end
`ifdef ALU_DIV_EN
          else if ((func == OP_DIVU) || (func == OP_REMU)) begin
            op_a_d  = b;
            op_b_d  = a;
            acc_d   = '0;
            cnt_d   = CNT_W'(WIDTH);
            func_d  = func;
            state_d = ST_DIV;
          end
`endif
          else begin
            out_d   = comb_result;
            zero_d  = comb_zero;
            neg_d   = comb_neg;
            ovf_d   = comb_ovf;
            carry_d = comb_carry;
            state_d = ST_HOLD;
          end
        end
      end

      ST_MUL: begin
        acc_d  = mul_acc_next;
        op_a_d = op_a_q << 1;
        op_b_d = op_b_q >> 1;
        cnt_d  = cnt_q - CNT_W'(1);
        if (last_step) begin
          out_d   = mul_acc_next;
          zero_d  = (mul_acc_next == '0);
          neg_d   = mul_acc_next[WIDTH-1];
          ovf_d   = 1'b0;
          carry_d = 1'b0;
          state_d = ST_HOLD;
        end
      end

`ifdef ALU_DIV_EN
      ST_DIV: begin
        acc_d  = div_rem_next;
        op_b_d = div_quo_next;
        cnt_d  = cnt_q - CNT_W'(1);
        if (last_step) begin
          out_d   = div_result;
          zero_d  = (div_result == '0);
          neg_d   = div_result[WIDTH-1];
          ovf_d   = 1'b0;
          carry_d = 1'b0;
          state_d = ST_HOLD;
        end
      end
`endif

      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset along with the state, because the
  // result and flag outputs are driven straight from them and must read 0
  // after reset; an in-flight multiply is discarded the same way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      carry_q <= 1'b0;
`ifdef ALU_DIV_EN
      func_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same
      // edge independent of statement order.
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      carry_q <= carry_d;
`ifdef ALU_DIV_EN
      func_q  <= func_d;
`endif
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_HOLD);
`ifdef ALU_DIV_EN
  assign busy       = (state_q == ST_MUL) || (state_q == ST_DIV);
`else
  assign busy       = (state_q == ST_MUL);
`endif
  assign out        = out_q;
  assign zero_flag  = zero_q;
  assign neg_flag   = neg_q;
  assign ovf_flag   = ovf_q;
  assign carry_flag = carry_q;

endmodule : alu_seq

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
//   Self-checking bench for alu_seq (WIDTH=32). A table of vectors is applied
//   one operation at a time; expected results are queued when an operation is
//   accepted and popped when the DUT presents its result. Hand-written
//   sequences cover multiply latency/busy, result hold under back-pressure,
//   ignored offers while busy and asynchronous reset mid-multiply.
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W       = 32;
  localparam int MUL_LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   func = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out;
  logic         zero_flag, neg_flag, ovf_flag, carry_flag, busy;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .func       (func),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .zero_flag  (zero_flag),
    .neg_flag   (neg_flag),
    .ovf_flag   (ovf_flag),
    .carry_flag (carry_flag),
    .busy       (busy)
  );

  // flags packed as {zero, neg, ovf, carry}
  typedef struct {
    string        name;
    logic [3:0]   func;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   flags;
    int           lat;
  } vec_t;

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic [3:0]   flags;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [3:0] f, input logic [W-1:0] x,
                              input logic [W-1:0] y, input logic [W-1:0] r,
                              input logic [3:0] fl, input int lat);
    vec_t v;
    v.name = name; v.func = f; v.a = x; v.b = y; v.res = r; v.flags = fl; v.lat = lat;
    return v;
  endfunction

  // Reference model for randomised vectors, written from the arithmetic
  // definitions using wide signed/unsigned math.
  function automatic vec_t model(input string name, input logic [3:0] f,
                                 input logic [W-1:0] x, input logic [W-1:0] y);
    longint       sx, sy, sr;
    logic [63:0]  ux, uy, ur;
    logic [W-1:0] r;
    logic         o, c;
    sx = longint'($signed(x)); sy = longint'($signed(y));
    ux = 64'(x); uy = 64'(y);
    o = 1'b0; c = 1'b0; r = '0;
    case (f)
      OP_ADD: begin
        ur = ux + uy; r = ur[W-1:0]; c = ur[W];
        sr = sx + sy; o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      OP_SUB: begin
        ur = ux - uy; r = ur[W-1:0]; c = (ux < uy);
        sr = sx - sy; o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      OP_AND:  r = x & y;
      OP_SLT:  r = (sx < sy) ? 1 : 0;
      OP_SLTU: r = (ux < uy) ? 1 : 0;
      OP_SRA:  begin sr = sx >>> y[4:0]; r = sr[W-1:0]; end
      OP_MUL:  begin ur = ux * uy; r = ur[W-1:0]; end
      default: r = '0;
    endcase
    return mk(name, f, x, y, r, {(r == '0), r[W-1], o, c}, (f == OP_MUL) ? MUL_LAT : 1);
  endfunction

  // Issue one operation from IDLE (called at a falling edge) and check the
  // result it produces, its latency and the return to IDLE.
  task automatic run_vec(input vec_t v);
    int   lat;
    exp_t e;
    check({v.name, " in_ready before"}, 64'(in_ready), 64'd1);
    func = v.func; a = v.a; b = v.b; in_valid = 1'b1;
    @(posedge clk);
    e.name = v.name; e.res = v.res; e.flags = v.flags;
    sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({v.name, " latency"}, 64'(lat), 64'(v.lat));
    if (out_valid && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({e.name, " out"}, 64'(out), 64'(e.res));
      check({e.name, " flags"}, 64'({zero_flag, neg_flag, ovf_flag, carry_flag}), 64'(e.flags));
    end
    @(negedge clk);
    check({v.name, " idle after take"}, 64'({in_ready, out_valid}), 64'b10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt;
    logic [W-1:0] held;
    logic [3:0]   rfuncs [7];

    vecs.push_back(mk("add_ovf",   OP_ADD,  32'h7FFF_FFFF, 32'h1,          32'h8000_0000, 4'b0110, 1));
    vecs.push_back(mk("sub_eq",    OP_SUB,  32'd5,         32'd5,          32'h0,         4'b1000, 1));
    vecs.push_back(mk("slt_neg",   OP_SLT,  32'hFFFF_FFFF, 32'h1,          32'h1,         4'b0000, 1));
    vecs.push_back(mk("sltu_big",  OP_SLTU, 32'hFFFF_FFFF, 32'h1,          32'h0,         4'b1000, 1));
    vecs.push_back(mk("slt_pos",   OP_SLT,  32'h1,         32'hFFFF_FFFF,  32'h0,         4'b1000, 1));
    vecs.push_back(mk("sra_4",     OP_SRA,  32'h8000_0000, 32'h24,         32'hF800_0000, 4'b0100, 1));
    vecs.push_back(mk("srl_4",     OP_SRL,  32'h8000_0000, 32'h24,         32'h0800_0000, 4'b0000, 1));
    vecs.push_back(mk("add_carry", OP_ADD,  32'hFFFF_FFFF, 32'h1,          32'h0,         4'b1001, 1));
    vecs.push_back(mk("sub_borrow",OP_SUB,  32'h0,         32'h1,          32'hFFFF_FFFF, 4'b0101, 1));
    vecs.push_back(mk("sub_ovf",   OP_SUB,  32'h8000_0000, 32'h1,          32'h7FFF_FFFF, 4'b0010, 1));
    vecs.push_back(mk("and",       OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00,  32'hF000_F000, 4'b0100, 1));
    vecs.push_back(mk("or",        OP_OR,   32'h0F0F_0000, 32'h0000_00F0,  32'h0F0F_00F0, 4'b0000, 1));
    vecs.push_back(mk("nor",       OP_NOR,  32'h0,         32'h0,          32'hFFFF_FFFF, 4'b0100, 1));
    vecs.push_back(mk("sll_31",    OP_SLL,  32'h1,         32'h1F,         32'h8000_0000, 4'b0100, 1));
    vecs.push_back(mk("sll_wrap",  OP_SLL,  32'h1234_5678, 32'h20,         32'h1234_5678, 4'b0000, 1));
    vecs.push_back(mk("undef_13",  4'd13,   32'h5,         32'h6,          32'h0,         4'b1000, 1));
    vecs.push_back(mk("undef_15",  4'd15,   32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0,         4'b1000, 1));
    vecs.push_back(mk("mul_ffff",  OP_MUL,  32'h0000_FFFF, 32'h0001_0001,  32'hFFFF_FFFF, 4'b0100, MUL_LAT));
    vecs.push_back(mk("mul_zero",  OP_MUL,  32'h0,         32'hDEAD_BEEF,  32'h0,         4'b1000, MUL_LAT));
    vecs.push_back(mk("mul_m1sq",  OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h1,         4'b0000, MUL_LAT));
`ifdef ALU_DIV_EN
    vecs.push_back(mk("divu",      OP_DIVU, 32'd100,       32'd7,          32'd14,        4'b0000, MUL_LAT));
    vecs.push_back(mk("remu",      OP_REMU, 32'd100,       32'd7,          32'd2,         4'b0000, MUL_LAT));
    vecs.push_back(mk("divu_z",    OP_DIVU, 32'd9,         32'd0,          32'hFFFF_FFFF, 4'b0100, MUL_LAT));
    vecs.push_back(mk("remu_z",    OP_REMU, 32'd9,         32'd0,          32'd9,         4'b0000, MUL_LAT));
`else
    vecs.push_back(mk("undef_11",  OP_DIVU, 32'd100,       32'd7,          32'h0,         4'b1000, 1));
    vecs.push_back(mk("undef_12",  OP_REMU, 32'd100,       32'd7,          32'h0,         4'b1000, 1));
`endif
    rfuncs = '{OP_ADD, OP_SUB, OP_AND, OP_SLT, OP_SLTU, OP_SRA, OP_MUL};
    for (int i = 0; i < 10; i++) begin
      vecs.push_back(model($sformatf("rand%0d", i), rfuncs[$urandom_range(0, 6)],
                           $urandom(), $urandom()));
    end

    // ---- reset state ----
    #1 rst_n = 1'b0;
    #1;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset outputs", 64'({out_valid, busy, zero_flag, neg_flag, ovf_flag, carry_flag}), 64'd0);
    check("reset out", 64'(out), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- table-driven vectors ----
    foreach (vecs[i]) run_vec(vecs[i]);

    // ---- MUL: busy for WIDTH cycles, offers ignored, then result held ----
    out_ready = 1'b0;
    func = OP_MUL; a = 32'h0000_FFFF; b = 32'h0001_0001; in_valid = 1'b1;
    @(posedge clk);
    sb_q.push_back('{name: "mul_hold", res: 32'hFFFF_FFFF, flags: 4'b0100});
    @(negedge clk);
    // keep offering an ADD while busy; it must never be accepted
    func = OP_ADD; a = 32'd1; b = 32'd1;
    cnt = 0;
    for (int i = 0; i < W; i++) begin
      if (busy && !in_ready && !out_valid) cnt++;
      @(negedge clk);
    end
    check("mul busy cycles", 64'(cnt), 64'(W));
    check("mul valid at W+1", 64'({out_valid, busy, in_ready}), 64'b100);
    held = out;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("mul_hold out", 64'(out), 64'(e.res));
      check("mul_hold flags", 64'({zero_flag, neg_flag, ovf_flag, carry_flag}), 64'(e.flags));
    end
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid && !in_ready && out === held) cnt++;
    end
    check("hold stable cycles", 64'(cnt), 64'd10);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("hold released", 64'({in_ready, out_valid}), 64'b10);
    check("out kept after take", 64'(out), 64'hFFFF_FFFF);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_valid || busy) cnt++;
    end
    check("no phantom op", 64'(cnt), 64'd0);
    check("scoreboard drained", 64'(sb_q.size()), 64'd0);

    // ---- asynchronous reset at MUL cycle 10 ----
    func = OP_MUL; a = 32'd3; b = 32'd5; in_valid = 1'b1;
    @(posedge clk);
    sb_q.push_back('{name: "mul_aborted", res: 32'd15, flags: 4'b0000});
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i < 10; i++) @(negedge clk);
    check("busy before reset", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    sb_q.delete();
    check("reset mid-mul state", 64'({in_ready, out_valid, busy}), 64'b100);
    check("reset mid-mul out", 64'(out), 64'd0);
    check("reset mid-mul flags", 64'({zero_flag, neg_flag, ovf_flag, carry_flag}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(mk("add_after_rst", OP_ADD, 32'd2, 32'd3, 32'd5, 4'b0000, 1));
    check("scoreboard empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_alu_seq
